// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: RAM style constants and
// parameter range checks.
// Build option: none here; SYNC_C1TX_FIFO_ASSERT_EN is consumed by sync_c1tx_fifo.
package sync_fifo_pkg;

  // RAM style hints: 0/1 map onto LUT-based RAM, 2/3 onto block RAM.
  localparam int unsigned GRAM_AUTO         = 0;
  localparam int unsigned GRAM_LUTRAM       = 1;
  localparam int unsigned GRAM_BLOCK        = 2;
  localparam int unsigned GRAM_BLOCK_NORW   = 3;
  localparam int unsigned GRAM_MODE_DEFAULT = GRAM_BLOCK_NORW;
  localparam int unsigned GRAM_MODE_MAX     = 3;

  // A zero-width control field still needs a one-bit port.
  function automatic int unsigned ctl_port_width(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit full_thresh_ok(input int unsigned thresh,
                                        input int unsigned depth_base2);
    return (thresh >= 1) && (thresh <= (32'd1 << depth_base2));
  endfunction

  function automatic bit gram_mode_ok(input int unsigned mode);
    return mode <= GRAM_MODE_MAX;
  endfunction

  function automatic bit gram_is_lutram(input int unsigned mode);
    return mode <= GRAM_LUTRAM;
  endfunction

endpackage

// File: rtl/sync_c1tx_fifo_ram.sv
// Simple dual-port RAM, D x DATA_WIDTH, with registered read address and
// registered output (2-cycle read). Output holds when no read was issued and
// resets to zero; stored contents are never cleared.
module sync_c1tx_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH_BASE2 = 2,
  parameter int unsigned GRAM_MODE   = GRAM_MODE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [DEPTH_BASE2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   rd_en,
  input  logic [DEPTH_BASE2-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_BASE2;

  logic [DEPTH_BASE2-1:0] raddr_q;
  logic                   rd_v_q;
  logic [DATA_WIDTH-1:0]  rd_word;

  if (gram_is_lutram(GRAM_MODE)) begin : g_lutram
    (* ramstyle = "MLAB, no_rw_check" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    assign rd_word = mem[raddr_q];
  end else begin : g_block
    (* ramstyle = "M20K" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    assign rd_word = mem[raddr_q];
  end

  // T1: capture read address; the RAM array itself needs no reset.
  always_ff @(posedge clk) begin
    if (rd_en) raddr_q <= raddr;
  end

  // T1 valid and T2 output register; output only moves on a real read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v_q <= 1'b0;
      rdata  <= '0;
    end else begin
      rd_v_q <= rd_en;
      if (rd_v_q) rdata <= rd_word;
    end
  end

endmodule

// File: rtl/sync_c1tx_fifo.sv
// Single-clock FIFO for CCI-P c2 Tx MMIO read responses: status and control
// combinational from registered state, data two cycles after pop.
// Writes while full and pops while empty are dropped and set sticky flags.
// Build option SYNC_C1TX_FIFO_ASSERT_EN adds simulation-only checks.
module sync_c1tx_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned CTL_WIDTH   = 0,
  parameter int unsigned DEPTH_BASE2 = 2,
  parameter int unsigned GRAM_MODE   = GRAM_MODE_DEFAULT,
  parameter int unsigned FULL_THRESH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                fifo_din,
  input  logic [ctl_port_width(CTL_WIDTH)-1:0] fifo_ctlin,
  input  logic                                 fifo_wen,
  input  logic                                 fifo_rdack,
  output logic [DATA_WIDTH-1:0]                T2_fifo_dout,
  output logic [ctl_port_width(CTL_WIDTH)-1:0] T0_fifo_ctlout,
  output logic                                 T0_fifo_dout_v,
  output logic                                 T0_fifo_empty,
  output logic                                 T0_fifo_full,
  output logic [DEPTH_BASE2:0]                 T0_fifo_count,
  output logic                                 T0_fifo_almFull,
  output logic                                 T0_fifo_underflow,
  output logic                                 T0_fifo_overflow
);

  localparam int unsigned DEPTH      = 1 << DEPTH_BASE2;
  localparam int unsigned ALMF_LEVEL = DEPTH - FULL_THRESH;
  localparam logic [DEPTH_BASE2:0] DEPTH_CNT = DEPTH[DEPTH_BASE2:0];
  localparam logic [DEPTH_BASE2:0] ALMF_CNT  = ALMF_LEVEL[DEPTH_BASE2:0];

  logic [DEPTH_BASE2-1:0] wp;
  logic [DEPTH_BASE2-1:0] rp;
  logic [DEPTH_BASE2:0]   count;
  logic                   overflow;
  logic                   underflow;
  logic                   empty;
  logic                   full;
  logic                   wr_ok;
  logic                   rd_ok;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign wr_ok = fifo_wen && !full;
  assign rd_ok = fifo_rdack && !empty;

  assign T0_fifo_empty     = empty;
  assign T0_fifo_dout_v    = !empty;
  assign T0_fifo_full      = full;
  assign T0_fifo_count     = count;
  assign T0_fifo_almFull   = (count >= ALMF_CNT);
  assign T0_fifo_overflow  = overflow;
  assign T0_fifo_underflow = underflow;

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
      if (fifo_wen && full)    overflow  <= 1'b1;
      if (fifo_rdack && empty) underflow <= 1'b1;
    end
  end

  // Control side-band lives in flops so the head entry is visible in T0.
  if (CTL_WIDTH > 0) begin : g_ctl
    logic [CTL_WIDTH-1:0] ctl_mem [DEPTH];

    // Control write alongside the data write.
    always_ff @(posedge clk) begin
      if (wr_ok) ctl_mem[wp] <= fifo_ctlin;
    end

    assign T0_fifo_ctlout = ctl_mem[rp];
  end else begin : g_no_ctl
    logic unused_ctl;
    assign unused_ctl     = ^fifo_ctlin;
    assign T0_fifo_ctlout = 1'b0;
  end

  sync_c1tx_fifo_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_BASE2 (DEPTH_BASE2),
    .GRAM_MODE   (GRAM_MODE)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wp),
    .wdata (fifo_din),
    .rd_en (rd_ok),
    .raddr (rp),
    .rdata (T2_fifo_dout)
  );

`ifdef SYNC_C1TX_FIFO_ASSERT_EN
  // Reject an almost-full margin outside 1..D before the first clock.
  initial begin
    if (!full_thresh_ok(FULL_THRESH, DEPTH_BASE2)) begin
      $display("%m ERROR: FULL_THRESH %0d outside 1..%0d", FULL_THRESH, DEPTH);
      $finish;
    end
    if (!gram_mode_ok(GRAM_MODE)) begin
      $display("%m ERROR: GRAM_MODE %0d outside 0..%0d", GRAM_MODE, GRAM_MODE_MAX);
      $finish;
    end
  end

  // Stop the simulation on any dropped request.
  always @(posedge clk) begin
    if (!reset && fifo_wen && full) begin
      $display("%m ERROR: fifo overflow");
      $finish;
    end
    if (!reset && fifo_rdack && empty) begin
      $display("%m ERROR: fifo underflow");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_sync_c1tx_fifo.sv
// Directed bench for sync_c1tx_fifo with D = 4, CTL_WIDTH = 4, FULL_THRESH = 2.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_sync_c1tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] fifo_din;
  logic [3:0]  fifo_ctlin;
  logic        fifo_wen;
  logic        fifo_rdack;
  logic [63:0] T2_fifo_dout;
  logic [3:0]  T0_fifo_ctlout;
  logic        T0_fifo_dout_v;
  logic        T0_fifo_empty;
  logic        T0_fifo_full;
  logic [2:0]  T0_fifo_count;
  logic        T0_fifo_almFull;
  logic        T0_fifo_underflow;
  logic        T0_fifo_overflow;

  int n_vec  = 0;
  int n_miss = 0;

  sync_c1tx_fifo #(
    .DATA_WIDTH  (64),
    .CTL_WIDTH   (4),
    .DEPTH_BASE2 (2),
    .GRAM_MODE   (3),
    .FULL_THRESH (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_din          (fifo_din),
    .fifo_ctlin        (fifo_ctlin),
    .fifo_wen          (fifo_wen),
    .fifo_rdack        (fifo_rdack),
    .T2_fifo_dout      (T2_fifo_dout),
    .T0_fifo_ctlout    (T0_fifo_ctlout),
    .T0_fifo_dout_v    (T0_fifo_dout_v),
    .T0_fifo_empty     (T0_fifo_empty),
    .T0_fifo_full      (T0_fifo_full),
    .T0_fifo_count     (T0_fifo_count),
    .T0_fifo_almFull   (T0_fifo_almFull),
    .T0_fifo_underflow (T0_fifo_underflow),
    .T0_fifo_overflow  (T0_fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fifo_din   = '0;
    fifo_ctlin = '0;
    fifo_wen   = 1'b0;
    fifo_rdack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write1(input logic [63:0] d, input logic [3:0] c);
    fifo_din   = d;
    fifo_ctlin = c;
    fifo_wen   = 1'b1;
    fifo_rdack = 1'b0;
    step();
    idle_inputs();
  endtask

  logic [63:0] exp_stream [8];
  logic [63:0] exp_drain  [6];
  logic [2:0]  exp_cnt    [13];

  initial begin
    exp_stream = '{64'h0, 64'h0, 64'hA, 64'hB, 64'hC, 64'hC, 64'hC, 64'hC};
    exp_drain  = '{64'h0, 64'h10, 64'h11, 64'h12, 64'h13, 64'h13};
    exp_cnt    = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
                   3'd1, 3'd0, 3'd0};

    // Reset state after one idle cycle.
    do_reset();
    step();
    check("rst_empty", 64'(T0_fifo_empty), 64'd1);
    check("rst_dout_v", 64'(T0_fifo_dout_v), 64'd0);
    check("rst_count", 64'(T0_fifo_count), 64'd0);
    check("rst_dout", T2_fifo_dout, 64'd0);
    check("rst_full", 64'(T0_fifo_full), 64'd0);
    check("rst_almfull", 64'(T0_fifo_almFull), 64'd0);
    check("rst_ovf", 64'(T0_fifo_overflow), 64'd0);
    check("rst_unf", 64'(T0_fifo_underflow), 64'd0);

    // Stream A, B, C with rdack tied to dout_v: data appears 2 cycles after pop.
    for (int i = 0; i < 8; i++) begin
      fifo_wen   = (i < 3);
      fifo_din   = 64'hA + 64'(i);
      fifo_rdack = T0_fifo_dout_v;
      step();
      check($sformatf("stream_dout[%0d]", i), T2_fifo_dout, exp_stream[i]);
    end
    idle_inputs();
    check("stream_empty", 64'(T0_fifo_empty), 64'd1);

    // Fill to full, overflow with a 5th write, then drain.
    do_reset();
    write1(64'h10, 4'h5);
    check("fill1_count", 64'(T0_fifo_count), 64'd1);
    check("fill1_almfull", 64'(T0_fifo_almFull), 64'd0);
    check("fill1_ctl", 64'(T0_fifo_ctlout), 64'h5);
    write1(64'h11, 4'h9);
    check("fill2_almfull", 64'(T0_fifo_almFull), 64'd1);
    check("fill2_full", 64'(T0_fifo_full), 64'd0);
    write1(64'h12, 4'h3);
    write1(64'h13, 4'h7);
    check("fill4_count", 64'(T0_fifo_count), 64'd4);
    check("fill4_full", 64'(T0_fifo_full), 64'd1);
    check("fill4_ctl", 64'(T0_fifo_ctlout), 64'h5);
    check("fill4_ovf", 64'(T0_fifo_overflow), 64'd0);
    write1(64'h99, 4'hF);
    check("ovf_flag", 64'(T0_fifo_overflow), 64'd1);
    check("ovf_count", 64'(T0_fifo_count), 64'd4);
    for (int j = 0; j < 6; j++) begin
      fifo_rdack = T0_fifo_dout_v;
      step();
      if (j == 0) check("drain_ctl_next", 64'(T0_fifo_ctlout), 64'h9);
      check($sformatf("drain_dout[%0d]", j), T2_fifo_dout, exp_drain[j]);
    end
    idle_inputs();
    check("drain_count", 64'(T0_fifo_count), 64'd0);
    check("drain_ovf_sticky", 64'(T0_fifo_overflow), 64'd1);

    // Simultaneous write and pop at count 2, wrapping the pointers.
    do_reset();
    write1(64'h20, 4'h0);
    write1(64'h21, 4'h0);
    for (int i = 0; i < 13; i++) begin
      fifo_wen   = (i < 10);
      fifo_din   = 64'h22 + 64'(i);
      fifo_rdack = T0_fifo_dout_v;
      step();
      check($sformatf("mix_count[%0d]", i), 64'(T0_fifo_count), 64'(exp_cnt[i]));
      if (i >= 1)
        check($sformatf("mix_dout[%0d]", i), T2_fifo_dout, 64'h20 + 64'(i - 1));
    end
    idle_inputs();
    check("mix_ovf", 64'(T0_fifo_overflow), 64'd0);

    // Pop while empty: flag set, no pointer movement.
    do_reset();
    fifo_rdack = 1'b1;
    step();
    idle_inputs();
    check("unf_flag", 64'(T0_fifo_underflow), 64'd1);
    check("unf_count", 64'(T0_fifo_count), 64'd0);
    check("unf_empty", 64'(T0_fifo_empty), 64'd1);
    check("unf_dout", T2_fifo_dout, 64'd0);
    write1(64'h55, 4'h2);
    check("unf_ctl_head", 64'(T0_fifo_ctlout), 64'h2);
    fifo_rdack = 1'b1;
    step();
    idle_inputs();
    step();
    check("unf_dout_after", T2_fifo_dout, 64'h55);
    check("unf_sticky", 64'(T0_fifo_underflow), 64'd1);
    do_reset();
    check("reset_clears_unf", 64'(T0_fifo_underflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
